// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch memory: word width,
// the internal error classification and the fetch-group lane mask helper.
package imem_pkg;

    localparam int IMEM_WORD_W = 32;

    // Debug classification of a fetch request; only NONE produces data.
    typedef enum logic [1:0] {
        IMEM_ERR_NONE     = 2'd0,
        IMEM_ERR_MISALIGN = 2'd1,
        IMEM_ERR_RANGE    = 2'd2
    } imem_err_e;

    // Lanes from the requested word up to the end of its group are valid;
    // lanes below the requested word, and lanes beyond the group, are not.
    function automatic logic [3:0] imemLaneMask(input int wordOff, input int fetchWords);
        logic [3:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[i] = (i >= wordOff) && (i < fetchWords);
        end
        return mask;
    endfunction

endpackage

// File: rtl/inst_fetch_rsp_fifo.sv
// Response buffer for the fetch memory: a small circular FIFO with
// asynchronous active-low reset and a synchronous clear used by flush.
// The producer guarantees it is never pushed while full, so no full flag.
module inst_fetch_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] popData_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Pointer and occupancy update; clear discards everything at once.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                wrPtr_d = nextPtr(wrPtr_q);
            end
            if (pop_i) begin
                rdPtr_d = nextPtr(rdPtr_q);
            end
            if (push_i && !pop_i) begin
                count_d = count_q + 1'b1;
            end else if (!push_i && pop_i) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            entries_q[wrPtr_q] <= pushData_i;
        end
    end

    assign empty_o   = (count_q == '0);
    assign popData_o = entries_q[rdPtr_q];

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: synchronous-read ROM returning a fetch group per
// accepted request, with credit-based flow control, a response buffer for
// backpressure, flush and address-error reporting.
// Optional build macro IMEM_LOAD_PORT_EN adds a byte-enabled load port.
module inst_fetch_mem
    import imem_pkg::*;
#(
    parameter int IROM_SPACE  = 4096,
    parameter int FETCH_WORDS = 2,
    parameter int RD_LATENCY  = 1,
    parameter int OUT_DEPTH   = 2
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [31:0]                        req_addr,
    input  logic                               flush,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [31:0]                        rsp_addr,
    output logic [IMEM_WORD_W*FETCH_WORDS-1:0] rsp_inst,
    output logic [FETCH_WORDS-1:0]             rsp_mask,
    output logic                               rsp_err
`ifdef IMEM_LOAD_PORT_EN
    ,
    input  logic                               ld_en,
    input  logic [$clog2(IROM_SPACE)-1:0]      ld_addr,
    input  logic [31:0]                        ld_data,
    input  logic [3:0]                         ld_be
`endif
);

    localparam int AW  = $clog2(IROM_SPACE);
    localparam int IW  = IMEM_WORD_W * FETCH_WORDS;
    localparam int PLW = 32 + IW + FETCH_WORDS + 1;
    localparam int CW  = $clog2(OUT_DEPTH + 1);

    // Word array; preloaded from outside, optionally written via the load port.
    logic [IMEM_WORD_W-1:0] romArray_q [IROM_SPACE];

    logic                   readyEn_q;
    logic [CW-1:0]          credit_q, credit_d;
    logic                   accept;
    logic                   deliver;
    logic                   loadBlock;

    logic [AW-1:0]          wordIdx;
    logic [AW-1:0]          laneOff;
    logic [AW-1:0]          groupBase;
    imem_err_e              errCode;
    logic                   isErr;
    logic [FETCH_WORDS-1:0] laneMask;
    logic [IW-1:0]          readData;
    logic [PLW-1:0]         readPayload;

    logic [RD_LATENCY-1:0]  stgValid_q;
    logic [PLW-1:0]         stgPayload_q [RD_LATENCY];
    logic                   lastValid;
    logic [PLW-1:0]         lastPayload;

    logic                   fifoEmpty;
    logic [PLW-1:0]         fifoHead;
    logic                   fifoPush;
    logic                   fifoPop;
    logic [PLW-1:0]         outPayload;

`ifdef IMEM_LOAD_PORT_EN
    assign loadBlock = ld_en;
`else
    assign loadBlock = 1'b0;
`endif

    // Request decode: word index, group position, error class and lane data.
    always_comb begin
        wordIdx   = req_addr[AW+1:2];
        laneOff   = wordIdx & AW'(FETCH_WORDS - 1);
        groupBase = wordIdx & ~AW'(FETCH_WORDS - 1);
        if (req_addr[1:0] != 2'b00) begin
            errCode = IMEM_ERR_MISALIGN;
        end else if (req_addr[31:AW+2] != '0) begin
            errCode = IMEM_ERR_RANGE;
        end else begin
            errCode = IMEM_ERR_NONE;
        end
        isErr    = (errCode != IMEM_ERR_NONE);
        laneMask = isErr ? '0 : FETCH_WORDS'(imemLaneMask(int'(laneOff), FETCH_WORDS));
        readData = '0;
        for (int i = 0; i < FETCH_WORDS; i++) begin
            if (laneMask[i]) begin
                readData[i*IMEM_WORD_W +: IMEM_WORD_W] = romArray_q[groupBase + AW'(i)];
            end
        end
        readPayload = {req_addr, readData, laneMask, isErr};
    end

    assign accept = req_valid && req_ready;

    // Read pipeline: stage 0 is the synchronous array read, enabled only on accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stgValid_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                stgPayload_q[s] <= '0;
            end
        end else if (flush) begin
            stgValid_q <= '0;
        end else begin
            stgValid_q[0] <= accept;
            if (accept) begin
                stgPayload_q[0] <= readPayload;
            end
            for (int s = 1; s < RD_LATENCY; s++) begin
                stgValid_q[s] <= stgValid_q[s-1];
                if (stgValid_q[s-1]) begin
                    stgPayload_q[s] <= stgPayload_q[s-1];
                end
            end
        end
    end

    assign lastValid   = stgValid_q[RD_LATENCY-1];
    assign lastPayload = stgPayload_q[RD_LATENCY-1];

    // A finished read bypasses the buffer only when the buffer is empty and
    // the consumer takes it now; otherwise it queues behind older responses.
    assign fifoPush = lastValid && !(fifoEmpty && rsp_ready);
    assign fifoPop  = !fifoEmpty && rsp_ready;

    inst_fetch_rsp_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (PLW)
    ) u_rspFifo (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .clear_i    (flush),
        .push_i     (fifoPush),
        .pushData_i (lastPayload),
        .pop_i      (fifoPop),
        .empty_o    (fifoEmpty),
        .popData_o  (fifoHead)
    );

    assign rsp_valid  = !fifoEmpty || lastValid;
    assign deliver    = rsp_valid && rsp_ready;
    assign outPayload = !fifoEmpty ? fifoHead : (lastValid ? lastPayload : '0);
    assign {rsp_addr, rsp_inst, rsp_mask, rsp_err} = outPayload;

    // Outstanding responses (in flight plus buffered); bounded by OUT_DEPTH
    // so the buffer can always absorb every issued read.
    always_comb begin
        credit_d = credit_q;
        if (flush) begin
            credit_d = '0;
        end else if (accept && !deliver) begin
            credit_d = credit_q + 1'b1;
        end else if (!accept && deliver) begin
            credit_d = credit_q - 1'b1;
        end
    end

    // Credit counter and the post-reset enable that opens the request port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit_q  <= '0;
            readyEn_q <= 1'b0;
        end else begin
            credit_q  <= credit_d;
            readyEn_q <= 1'b1;
        end
    end

    assign req_ready = readyEn_q && !flush && !loadBlock && (credit_q < CW'(OUT_DEPTH));

`ifdef IMEM_LOAD_PORT_EN
    // Byte-enabled array write; visible to a read accepted on a later edge.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ld_be[b]) begin
                    romArray_q[ld_addr][b*8 +: 8] <= ld_data[b*8 +: 8];
                end
            end
        end
    end
`endif

endmodule

// File: doc/inst_fetch_mem.md
Name: inst_fetch_mem

Overview:
- Next-generation instruction memory: synchronous-read ROM array with a valid/ready request/response handshake.
- Multi-word fetch groups, configurable read latency, a response buffer for backpressure, flush, and address-error reporting.
- Sits between the IF-stage PC generator and the fetch/decode queue.
- Replaces the fixed single-word, always-enabled instruction ROM.

Parameters:
- IROM_SPACE, 4096: depth in 32-bit words; power of two, 256..65536.
- FETCH_WORDS, 2: words returned per fetch group; 1, 2 or 4.
- RD_LATENCY, 1: array read pipeline stages; 1 or 2.
- OUT_DEPTH, 2: response buffer entries; at least RD_LATENCY+1.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  32  byte address of first instruction.
- flush  in  1  discard all in-flight and buffered responses.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_addr  out  32  req_addr of this response.
- rsp_inst  out  32*FETCH_WORDS  word i at bits [32i+31:32i].
- rsp_mask  out  FETCH_WORDS  bit i set = word i valid.
- rsp_err  out  1  misaligned or out-of-range request.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_err=0.
  - rsp_addr=0, rsp_inst=0, rsp_mask=0.
  - Credit counter=0, pipeline valids=0.
  - req_ready rises the first cycle after rstn deasserts.
- Addressing:
  - Word index w = req_addr[AW+1:2], where AW = log2(IROM_SPACE).
  - Group base b = w with its low log2(FETCH_WORDS) bits cleared.
  - Words w..b+FETCH_WORDS-1 are returned, placed at lanes (w-b)..FETCH_WORDS-1.
  - rsp_mask sets exactly those lanes; lower lanes are 0 in both data and mask.
  - No wrap past the group end.
- Errors:
  - Error if req_addr[1:0]!=0 or req_addr >= 4*IROM_SPACE.
  - On error: rsp_err=1, rsp_mask=0, rsp_inst=0. The response still occupies one slot, in order.
- Latency: an accepted request gives rsp_valid exactly RD_LATENCY cycles later when the buffer is empty and rsp_ready=1.
- Throughput: one request per cycle.
- Ordering: responses are strictly in request order.
- Credit flow control:
  - count = in-flight + buffered.
  - req_ready = !flush && rstn_synced && (count < OUT_DEPTH).
  - Accept and pop in the same cycle keep count unchanged.
  - Count never exceeds OUT_DEPTH; buffer overflow is impossible by construction.
- Backpressure:
  - rsp_valid, once high, holds until rsp_ready.
  - rsp_addr, rsp_inst, rsp_mask and rsp_err stay stable while rsp_valid && !rsp_ready.
- Flush:
  - In the flush cycle, any request is not accepted.
  - Next cycle: all pipeline valids and buffer entries are cleared, rsp_valid=0, count=0.
  - A response handshaken in the flush cycle itself counts as delivered.
- Reset mid-operation: everything clears asynchronously; nothing in flight survives.
- Array:
  - Register array, read-only in normal operation.
  - Initialised by the bench via $readmemh on the array.
  - Read enable only on accepted requests, so array outputs do not toggle when idle.

Optional Feature:
- Macro: IMEM_LOAD_PORT_EN.
- When defined, the block adds these ports:
  - ld_en  in  1
  - ld_addr  in  log2(IROM_SPACE)
  - ld_data  in  32
  - ld_be  in  4
- Load port behaviour:
  - Byte-enabled write on the clk rising edge.
  - ld_en forces req_ready=0 that cycle.
  - A read issued one cycle after a write returns the new data.
- When not defined: the ports are absent, the array is read-only, and no write logic is synthesised.

Decomposition:
- Shared package imem_pkg:
  - Constants IMEM_WORD_W=32 and IMEM_ERR_NONE/IMEM_ERR_MISALIGN/IMEM_ERR_RANGE (internal debug encoding).
  - A function computing the lane mask from (word offset, FETCH_WORDS).
- One sub-module: inst_fetch_rsp_fifo.
  - Parametrised depth/width FIFO with synchronous clear (flush) and async reset.
  - Carries {addr, inst, mask, err}.

Test Plan:
- Reset release, FETCH_WORDS=2, array word k = 0x1000_0000+k; request 0x0000_0008 with rsp_ready=1 → after RD_LATENCY cycles: rsp_inst={0x10000003,0x10000002}, mask=2'b11, err=0.
- Unaligned-in-group: request 0x0000_000C → rsp_inst lane1=0x10000003, lane0=0, mask=2'b10.
- Errors: request 0x0000_0006 → err=1, mask=0. Request 0x0000_4000 (IROM_SPACE=4096) → err=1. A valid request immediately after returns normally, in order.
- Backpressure: rsp_ready=0, issue requests back-to-back → req_ready drops after OUT_DEPTH accepts. Hold 10 cycles with outputs stable. Raise rsp_ready → all OUT_DEPTH responses arrive in order, no loss or duplication.
- Flush: 2 requests in flight, assert flush 1 cycle → next cycle rsp_valid=0 and the stale responses never appear. A new request at 0x0000_0010 returns word 4/5 data.
- Async reset mid-stream: drop rstn between clock edges while rsp_valid=1 → outputs clear immediately. After release, the first response corresponds to the first post-reset request.
